// File: rtl/fib_pkg.sv
// Shared types and width helpers for the FIB longest-prefix-match engine.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    RESP  = 2'd2
  } lkp_state_e;

  typedef enum logic {
    UPD_INSERT = 1'b0,
    UPD_DELETE = 1'b1
  } upd_op_e;

  function automatic int len_width(input int prefix_w);
    return $clog2(prefix_w + 1);
  endfunction

  function automatic int cnt_width(input int prefix_w, input int hash_w);
    return $clog2((prefix_w + 1) * (1 << hash_w) + 1);
  endfunction

endpackage

// File: rtl/fib_hash.sv
// Bucket hash: keep the top len bits of the prefix, XOR-fold into HASH_W chunks
// from the LSB, then mix in the length. len_i must already be saturated.
module fib_hash
  import fib_pkg::*;
#(
  parameter int PREFIX_W = 64,
  parameter int HASH_W   = 10
) (
  input  logic [PREFIX_W-1:0]            prefix_i,
  input  logic [len_width(PREFIX_W)-1:0] len_i,
  output logic [HASH_W-1:0]              hash_o
);

  localparam int NCHUNK = (PREFIX_W + HASH_W - 1) / HASH_W;
  localparam int PAD_W  = NCHUNK * HASH_W;

  logic [PREFIX_W-1:0] key;
  logic [PAD_W-1:0]    key_pad;
  logic [HASH_W-1:0]   chunk [NCHUNK];
  logic [HASH_W-1:0]   fold;

  assign key     = prefix_i & ~({PREFIX_W{1'b1}} >> len_i);
  assign key_pad = PAD_W'(key);

  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign chunk[gi] = key_pad[gi*HASH_W +: HASH_W];
    end
  endgenerate

  always_comb begin
    fold = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      fold = fold ^ chunk[i];
    end
  end

  assign hash_o = fold ^ HASH_W'(len_i);

endmodule

// File: rtl/fib_lpm.sv
// Forwarding information base: per-length hash buckets of {valid, face} with a
// sequential longest-prefix-match probe from the requested length down to 0.
module fib_lpm
  import fib_pkg::*;
#(
  parameter int PREFIX_W     = 64,
  parameter int HASH_W       = 10,
  parameter int FACE_W       = 4,
  parameter int DEFAULT_FACE = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   upd_valid,
  input  logic                                   upd_del,
  input  logic [PREFIX_W-1:0]                    upd_prefix,
  input  logic [len_width(PREFIX_W)-1:0]         upd_len,
  input  logic [FACE_W-1:0]                      upd_face,
  input  logic                                   lkp_valid,
  output logic                                   lkp_ready,
  input  logic [PREFIX_W-1:0]                    lkp_prefix,
  input  logic [len_width(PREFIX_W)-1:0]         lkp_len,
  output logic                                   rsp_valid,
  input  logic                                   rsp_ready,
  output logic                                   rsp_hit,
  output logic [len_width(PREFIX_W)-1:0]         rsp_len,
  output logic [FACE_W-1:0]                      rsp_face,
  output logic [cnt_width(PREFIX_W, HASH_W)-1:0] entry_count
);

  localparam int LEN_W       = len_width(PREFIX_W);
  localparam int CNT_W       = cnt_width(PREFIX_W, HASH_W);
  localparam int ADDR_W      = LEN_W + HASH_W;
  localparam int NUM_ENTRIES = (PREFIX_W + 1) * (1 << HASH_W);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PREFIX_W);

  lkp_state_e state_q, state_d;
  upd_op_e    upd_op;

  logic [NUM_ENTRIES-1:0] valid_q;
  logic [FACE_W-1:0]      face_mem [NUM_ENTRIES];
  logic [CNT_W-1:0]       entry_count_q;

  logic [LEN_W-1:0]    upd_len_sat, lkp_len_sat;
  logic [HASH_W-1:0]   upd_hash, probe_hash;
  logic [ADDR_W-1:0]   upd_addr, probe_addr;
  logic [PREFIX_W-1:0] lkp_key, key_q;
  logic [LEN_W-1:0]    cur_len_q, rd_len_q;
  logic                pend_q, rd_valid_q;
  logic [FACE_W-1:0]   rd_face_q;
  logic                rsp_hit_q;
  logic [LEN_W-1:0]    rsp_len_q;
  logic [FACE_W-1:0]   rsp_face_q;
  logic                probe_done;

  assign upd_op      = upd_op_e'(upd_del);
  assign upd_len_sat = (upd_len > MAX_LEN) ? MAX_LEN : upd_len;
  assign lkp_len_sat = (lkp_len > MAX_LEN) ? MAX_LEN : lkp_len;
  assign lkp_key     = lkp_prefix & ~({PREFIX_W{1'b1}} >> lkp_len_sat);

  fib_hash #(.PREFIX_W(PREFIX_W), .HASH_W(HASH_W)) u_upd_hash (
    .prefix_i (upd_prefix),
    .len_i    (upd_len_sat),
    .hash_o   (upd_hash)
  );

  fib_hash #(.PREFIX_W(PREFIX_W), .HASH_W(HASH_W)) u_probe_hash (
    .prefix_i (key_q),
    .len_i    (cur_len_q),
    .hash_o   (probe_hash)
  );

  // Row-major layout: the length selects the row, so {len, hash} is the address.
  assign upd_addr   = {upd_len_sat, upd_hash};
  assign probe_addr = {cur_len_q, probe_hash};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q       <= '0;
      entry_count_q <= '0;
    end else if (upd_valid) begin
      if (upd_op == UPD_DELETE) begin
        if (valid_q[upd_addr]) entry_count_q <= entry_count_q - CNT_W'(1);
        valid_q[upd_addr] <= 1'b0;
      end else begin
        if (!valid_q[upd_addr]) entry_count_q <= entry_count_q + CNT_W'(1);
        valid_q[upd_addr] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (upd_valid && upd_op == UPD_INSERT) face_mem[upd_addr] <= upd_face;
    rd_face_q <= face_mem[probe_addr];
  end

  // Reads are registered, so a probe result is judged one cycle after it is
  // issued while the next-shorter length is already being read.
  assign probe_done = (state_q == PROBE) && pend_q && (rd_valid_q || rd_len_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q      <= '0;
      cur_len_q  <= '0;
      pend_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_len_q   <= '0;
      rsp_hit_q  <= 1'b0;
      rsp_len_q  <= '0;
      rsp_face_q <= '0;
    end else begin
      rd_valid_q <= valid_q[probe_addr];
      rd_len_q   <= cur_len_q;
      case (state_q)
        IDLE: begin
          if (lkp_valid) begin
            key_q     <= lkp_key;
            cur_len_q <= lkp_len_sat;
            pend_q    <= 1'b0;
          end
        end
        PROBE: begin
          pend_q <= 1'b1;
          if (cur_len_q != '0) cur_len_q <= cur_len_q - LEN_W'(1);
          if (probe_done) begin
            pend_q     <= 1'b0;
            rsp_hit_q  <= rd_valid_q;
            rsp_len_q  <= rd_valid_q ? rd_len_q : '0;
            rsp_face_q <= rd_valid_q ? rd_face_q : FACE_W'(DEFAULT_FACE);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (lkp_valid) state_d = PROBE;
      PROBE:   if (probe_done) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lkp_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
  end

  assign rsp_hit     = rsp_hit_q;
  assign rsp_len     = rsp_len_q;
  assign rsp_face    = rsp_face_q;
  assign entry_count = entry_count_q;

endmodule

// File: tb/tb_fib_lpm.sv
// Directed bench for fib_lpm: stimulus pushes expected responses into a queue,
// a negedge monitor pops and compares them, including response latency.
module tb_fib_lpm;

  localparam int PW = 16;
  localparam int HW = 4;
  localparam int FW = 4;
  localparam int DF = 15;
  localparam int LW = 5;
  localparam int CW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          upd_valid = 1'b0;
  logic          upd_del = 1'b0;
  logic [PW-1:0] upd_prefix = '0;
  logic [LW-1:0] upd_len = '0;
  logic [FW-1:0] upd_face = '0;
  logic          lkp_valid = 1'b0;
  logic          lkp_ready;
  logic [PW-1:0] lkp_prefix = '0;
  logic [LW-1:0] lkp_len = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_hit;
  logic [LW-1:0] rsp_len;
  logic [FW-1:0] rsp_face;
  logic [CW-1:0] entry_count;

  fib_lpm #(.PREFIX_W(PW), .HASH_W(HW), .FACE_W(FW), .DEFAULT_FACE(DF)) dut (
    .clk         (clk),
    .rst         (rst),
    .upd_valid   (upd_valid),
    .upd_del     (upd_del),
    .upd_prefix  (upd_prefix),
    .upd_len     (upd_len),
    .upd_face    (upd_face),
    .lkp_valid   (lkp_valid),
    .lkp_ready   (lkp_ready),
    .lkp_prefix  (lkp_prefix),
    .lkp_len     (lkp_len),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_hit     (rsp_hit),
    .rsp_len     (rsp_len),
    .rsp_face    (rsp_face),
    .entry_count (entry_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit  hit;
    int  len;
    int  face;
    int  lat;
    time t0;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   seen = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      seen = 1'b0;
    end else if (rsp_valid) begin
      if (sb.size() == 0) begin
        timeout("unexpected_rsp");
      end else begin
        if (!seen) begin
          seen = 1'b1;
          chk("rsp_latency", longint'(($time - 5 - sb[0].t0) / 10), sb[0].lat);
        end
        if (rsp_ready) begin
          e = sb.pop_front();
          seen = 1'b0;
          $display("rsp hit=%0d len=%0d face=%0d", rsp_hit, rsp_len, rsp_face);
          chk("rsp_hit", rsp_hit, e.hit);
          chk("rsp_len", rsp_len, e.len);
          chk("rsp_face", rsp_face, e.face);
        end
      end
    end
  end

  task automatic lookup(input logic [PW-1:0] p, input int l, input bit eh, input int el,
                        input int ef, input int lat, input bit wait_done);
    exp_t e;
    int   n;
    @(negedge clk);
    lkp_valid  = 1'b1;
    lkp_prefix = p;
    lkp_len    = LW'(l);
    n = 0;
    while (!lkp_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!lkp_ready) begin
      timeout("lkp_accept");
      lkp_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.hit = eh; e.len = el; e.face = ef; e.lat = lat; e.t0 = $time;
    sb.push_back(e);
    #1 lkp_valid = 1'b0;
    $display("lookup prefix=%h len=%0d", p, l);
    if (wait_done) begin
      n = 0;
      @(negedge clk);
      while (!(lkp_ready && sb.size() == 0) && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!(lkp_ready && sb.size() == 0)) timeout("lkp_complete");
    end
  endtask

  task automatic update(input bit del, input logic [PW-1:0] p, input int l, input int f,
                        input int exp_cnt);
    @(negedge clk);
    upd_valid  = 1'b1;
    upd_del    = del;
    upd_prefix = p;
    upd_len    = LW'(l);
    upd_face   = FW'(f);
    @(negedge clk);
    upd_valid = 1'b0;
    $display("update del=%0d prefix=%h len=%0d face=%0d count=%0d", del, p, l, f, entry_count);
    chk("entry_count", entry_count, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_entry_count", entry_count, 0);
    chk("rst_lkp_ready", lkp_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_hit", rsp_hit, 0);
    chk("rst_rsp_len", rsp_len, 0);
    chk("rst_rsp_face", rsp_face, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    lookup(16'hABCD, 16, 0, 0, DF, 18, 1);

    update(0, 16'hAB00, 8, 3, 1);
    lookup(16'hAB00, 8, 1, 8, 3, 2, 1);
    update(0, 16'hABC0, 12, 5, 2);
    lookup(16'hABCD, 16, 1, 12, 5, 6, 1);
    lookup(16'hABFF, 16, 1, 8, 3, 10, 1);
    lookup(16'hABCD, 31, 1, 12, 5, 6, 1);
    lookup(16'h1234, 0, 0, 0, DF, 2, 1);

    update(1, 16'hABC0, 12, 0, 1);
    update(0, 16'hAB00, 8, 7, 1);
    lookup(16'hAB00, 8, 1, 8, 7, 2, 1);
    lookup(16'hABCD, 16, 1, 8, 7, 10, 1);
    update(1, 16'hAB00, 8, 0, 0);
    lookup(16'hAB00, 8, 0, 0, DF, 10, 1);
    update(1, 16'hAB00, 8, 0, 0);

    update(0, 16'hABFF, 8, 9, 1);
    lookup(16'hAB12, 8, 1, 8, 9, 2, 1);
    update(0, 16'h5555, 0, 4, 2);
    lookup(16'h1234, 16, 1, 0, 4, 18, 1);

    // Backpressure: response must hold for five stalled cycles.
    rsp_ready = 1'b0;
    lookup(16'hAB12, 8, 1, 8, 9, 2, 0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) timeout("bp_rsp_valid");
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_lkp_ready", lkp_ready, 0);
      chk("bp_rsp_hit", rsp_hit, 1);
      chk("bp_rsp_len", rsp_len, 8);
      chk("bp_rsp_face", rsp_face, 9);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_done_rsp_valid", rsp_valid, 0);
    chk("bp_done_lkp_ready", lkp_ready, 1);

    // Reset in the middle of a probe sequence.
    lookup(16'hABCD, 16, 1, 8, 9, 10, 0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_lkp_ready_busy", lkp_ready, 0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_lkp_ready", lkp_ready, 1);
    chk("mid_rst_entry_count", entry_count, 0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    lookup(16'hAB00, 8, 0, 0, DF, 10, 1);
    lookup(16'h0000, 0, 0, 0, DF, 2, 1);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fib_lpm.md
# fib_lpm

Parametrised forwarding information base for the NDN router with a longest-prefix-match lookup engine. It holds per-length hash buckets, each with a valid bit and an outgoing face ID. Table writes arrive on an update port (insert/delete). Lookups from the PIT side probe from the requested length down to 0 and return the longest matching length and its face. It sits between the PIT and the outgoing interface arbiter.

## Interface
- PREFIX_W, 64: prefix width in bits; length range 0..PREFIX_W.
- HASH_W, 10: bucket index width; 2^HASH_W buckets per length class.
- FACE_W, 4: outgoing face ID width.
- DEFAULT_FACE, 0: face returned on a complete miss.
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- upd_valid  input  1  update request; always accepted, no ready.
- upd_del  input  1  0 = insert, 1 = delete.
- upd_prefix  input  PREFIX_W  prefix, MSB-aligned.
- upd_len  input  clog2(PREFIX_W+1)  significant prefix bits.
- upd_face  input  FACE_W  face to store on insert.
- lkp_valid / lkp_ready  input / output  1  lookup request handshake.
- lkp_prefix, lkp_len  input  PREFIX_W, clog2(PREFIX_W+1)  lookup key.
- rsp_valid / rsp_ready  output / input  1  response handshake.
- rsp_hit  output  1  a matching bucket was found.
- rsp_len  output  clog2(PREFIX_W+1)  matched length (0 on miss).
- rsp_face  output  FACE_W  matched face, or DEFAULT_FACE on miss.
- entry_count  output  clog2((PREFIX_W+1)*2^HASH_W+1)  number of valid buckets.

## Operation
- Key normalisation: keep the top len bits of the prefix and zero the rest. A len above PREFIX_W saturates to PREFIX_W.
- Hash: XOR-fold the masked prefix into HASH_W-bit chunks taken from the LSB; the last chunk is zero-padded. Then XOR with len, truncated or zero-extended to HASH_W.
- Table: (PREFIX_W+1) x 2^HASH_W entries of {valid, face}. Hash collisions alias by design: there is no tag, so a false-positive hit is permitted.
- Update, insert: set the valid bit and write the face. If the bucket was already valid, overwrite the face and leave entry_count unchanged; otherwise entry_count increments.
- Update, delete: clear the valid bit and decrement entry_count if the bucket was valid. Deleting an invalid bucket is a no-op.
- Lookup FSM:
  - IDLE: lkp_ready=1. On handshake, latch the normalised key and set cur_len = lkp_len → PROBE.
  - PROBE: read bucket [cur_len][hash(prefix, cur_len)].
    - Valid: latch hit=1, len=cur_len, face → RESP.
    - Invalid with cur_len==0: latch hit=0, len=0, DEFAULT_FACE → RESP.
    - Otherwise: decrement cur_len and stay in PROBE.
  - RESP: hold rsp_valid and the response fields stable until rsp_ready → IDLE.
- Reset mid-lookup: FSM returns to IDLE and any pending response is discarded.

## Timing
- Reset values: all valid bits 0, entry_count 0, lkp_ready 1, rsp_valid 0, rsp_hit 0, rsp_len 0, rsp_face 0.
- Lookup latency: handshake at edge T. A hit at the requested length gives rsp_valid after edge T+2. Each missed length adds one cycle; the worst case is lkp_len+2 cycles.
- lkp_ready is 0 in PROBE and RESP. There is one outstanding lookup at a time.
- An update is written at the edge where upd_valid=1. A PROBE in the same cycle reads the pre-update value.
- Back-to-back lookups: the IDLE cycle after the RESP handshake costs one cycle of lkp_ready=1 before the next key is accepted.
- entry_count saturates at neither bound in legal use. An insert and a delete to the same bucket cannot both occur in one cycle because the port is single-issue.

## Structure
- Package fib_pkg: lookup-state enum (IDLE, PROBE, RESP), length-width and count-width helper functions, and the update-op encoding.
- Sub-module fib_hash: combinational mask plus XOR-fold, parametrised by PREFIX_W and HASH_W. It is instantiated twice, once for the update path and once for the probe path.

## Test plan
All scenarios use PREFIX_W=16, HASH_W=4, FACE_W=4, DEFAULT_FACE=15.
- Reset and empty lookup: release rst, then look up 16'hABCD with len 16 → response after 18 cycles with hit=0, len=0, face=15; entry_count=0.
- Exact hit: insert 16'hAB00 with len 8, face 3; look up 16'hAB00 with len 8 → rsp_valid two cycles after the handshake, hit=1, len=8, face=3.
- Longest match: insert {AB00, len 8, face 3} and {ABC0, len 12, face 5}; look up 16'hABCD with len 16 → hit=1, len=12, face=5, with rsp_valid six cycles after the handshake.
- Overwrite and delete: insert {AB00, 8, 3}, then insert {AB00, 8, 7} → entry_count=1 and lookup returns face 7. Delete it → entry_count=0 and lookup misses. A second delete leaves entry_count at 0.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_* fields stay stable, lkp_ready=0; the handshake occurs on the first rsp_ready=1 cycle.
- Reset mid-probe: assert rst during PROBE → rsp_valid=0 and lkp_ready=1 immediately (asynchronously), and the table is cleared.
